// File: rtl/matrix_result_packer_pkg.sv
// Shared widths, state encoding and entry-to-slot mapping for the result packer.
// Used by the packer top level and its pair accumulator.
package matrix_result_packer_pkg;
  localparam int EW = 3;
  localparam int PW = 2 * EW;
  localparam int RW = 2 * EW + 1;
  localparam logic [3:0] ENTRY_LAST = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Each result element is built from an adjacent even/odd entry pair.
  function automatic logic [1:0] entry_slot(input logic [3:0] entry);
    return entry[2:1];
  endfunction
endpackage

// File: rtl/matrix_result_packer_pair.sv
// Holds the first product of a pair and forms the widened pair sum.
// Sum is combinational from acc and the current product; acc loads in one cycle.
module matrix_result_packer_pair #(
  parameter int PW = 6,
  parameter int RW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [PW-1:0] product,
  output logic [RW-1:0] sum
);
  logic [RW-1:0] acc;
  logic [RW-1:0] product_ext;

  assign product_ext = {{(RW-PW){1'b0}}, product};
  assign sum         = acc + product_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= product_ext;
    end
  end
endmodule

// File: rtl/matrix_result_packer.sv
// Sums entry-tagged product pairs into a packed 2x2 result; valid right after entry 7.
// Holds the result under valid/ready; in_ready is low while a result is pending.
module matrix_result_packer
  import matrix_result_packer_pkg::*;
#(
  parameter int EW = matrix_result_packer_pkg::EW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            entry,
  input  logic [2*EW-1:0]       product,
  output logic [4*(2*EW+1)-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  seq_err
);
  localparam int LPW = 2 * EW;
  localparam int LRW = 2 * EW + 1;

  state_t        state;
  logic [2:0]    exp;
  logic          accept;
  logic          in_order;
  logic          acc_load;
  logic [LRW-1:0] sum;

  assign in_ready = (state != FULL);
  assign accept   = in_valid && in_ready;
  assign in_order = (entry == {1'b0, exp});
  // An out-of-order entry 0 still opens a fresh frame, so it loads acc too.
  assign acc_load = accept && !entry[0] && (in_order || entry == 4'd0);

  matrix_result_packer_pair #(
    .PW(LPW),
    .RW(LRW)
  ) u_pair (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (acc_load),
    .product(product),
    .sum    (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      exp          <= 3'd0;
      result       <= '0;
      result_valid <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      case (state)
        FULL: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
            exp          <= 3'd0;
          end
        end
        default: begin
          if (accept) begin
            if (in_order) begin
              if (entry[0]) begin
                result[int'(entry_slot(entry))*LRW +: LRW] <= sum;
              end
              if (entry == ENTRY_LAST) begin
                result_valid <= 1'b1;
                state        <= FULL;
                exp          <= 3'd0;
              end else begin
                state <= ACCUM;
                exp   <= exp + 3'd1;
              end
            end else begin
              seq_err <= 1'b1;
              if (entry == 4'd0) begin
                state <= ACCUM;
                exp   <= 3'd1;
              end else begin
                state <= IDLE;
                exp   <= 3'd0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_packer.sv
// Directed bench for matrix_result_packer: vector table plus handshake, reset and gap sequences.
module tb_matrix_result_packer;
  import matrix_result_packer_pkg::*;

  typedef struct {
    logic [3:0]    entry;
    logic [PW-1:0] product;
    logic          exp_seq_err;
    logic          exp_valid;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      entry = 4'd0;
  logic [PW-1:0]   product = '0;
  logic [4*RW-1:0] result;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic            seq_err;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [4*RW-1:0] RES_A   = 28'h24AC313;
  localparam logic [4*RW-1:0] RES_MAX = {7'd98, 7'd98, 7'd98, 7'd98};

  vec_t tbl[22];

  matrix_result_packer #(.EW(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .entry       (entry),
    .product     (product),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    entry    = v.entry;
    product  = v.product;
    @(posedge clk);
    #1;
    check({tag, " seq_err"}, 32'(seq_err), 32'(v.exp_seq_err));
    check({tag, " result_valid"}, 32'(result_valid), 32'(v.exp_valid));
    check({tag, " in_ready"}, 32'(in_ready), 32'(!v.exp_valid));
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) apply(tbl[i], $sformatf("%s[%0d]", tag, i));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    in_valid     = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " valid cleared"}, 32'(result_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] e, input logic [PW-1:0] p,
                              input logic se, input logic v);
    vec_t r;
    r.entry = e; r.product = p; r.exp_seq_err = se; r.exp_valid = v;
    return r;
  endfunction

  initial begin
    // Frame A: A=[[1,2],[3,4]], B=[[5,6],[7,0]]
    tbl[0] = mk(4'd0, 6'd5, 0, 0);   tbl[1] = mk(4'd1, 6'd14, 0, 0);
    tbl[2] = mk(4'd2, 6'd6, 0, 0);   tbl[3] = mk(4'd3, 6'd0, 0, 0);
    tbl[4] = mk(4'd4, 6'd15, 0, 0);  tbl[5] = mk(4'd5, 6'd28, 0, 0);
    tbl[6] = mk(4'd6, 6'd18, 0, 0);  tbl[7] = mk(4'd7, 6'd0, 0, 1);
    // Out-of-order 3, then a restart on a repeated 0 followed by an all-49 frame
    tbl[8]  = mk(4'd0, 6'd1, 0, 0);  tbl[9]  = mk(4'd1, 6'd2, 0, 0);
    tbl[10] = mk(4'd3, 6'd3, 1, 0);  tbl[11] = mk(4'd0, 6'd9, 0, 0);
    tbl[12] = mk(4'd1, 6'd9, 0, 0);  tbl[13] = mk(4'd0, 6'd49, 1, 0);
    for (int i = 1; i <= 7; i++) tbl[13+i] = mk(4'(i), 6'd49, 0, i == 7);
    tbl[21] = mk(4'd8, 6'd1, 1, 0);

    #12;
    check("reset result", result[31:0] & 32'hFFFFFFF, 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset seq_err", 32'(seq_err), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_vecs(0, 7, "frameA");
    check("frameA result", 32'(result), 32'(RES_A));

    // Stall: entry 0 offered while FULL must be ignored
    @(negedge clk);
    in_valid = 1'b1; entry = 4'd0; product = 6'd33;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d result", c), 32'(result), 32'(RES_A));
      check($sformatf("stall%0d valid", c), 32'(result_valid), 32'd1);
    end
    handshake("hsA");

    run_vecs(8, 20, "seq");
    check("max result", 32'(result), 32'(RES_MAX));
    handshake("hsMax");
    run_vecs(21, 21, "entry8");

    // Async reset after entry 4 of a partially written frame
    run_vecs(0, 4, "pre_rst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst result", 32'(result), 32'd0);
    check("arst result_valid", 32'(result_valid), 32'd0);
    check("arst seq_err", 32'(seq_err), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vecs(0, 7, "post_rst");
    check("post_rst result", 32'(result), 32'(RES_A));
    handshake("hsRst");

    // Frame A again with an idle cycle between every pair
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i], $sformatf("gap[%0d]", i));
      if (i < 7) begin
        @(negedge clk);
        in_valid = 1'b0;
        entry    = 4'd15;
        @(posedge clk);
        #1;
        check($sformatf("gap idle%0d valid", i), 32'(result_valid), 32'd0);
        check($sformatf("gap idle%0d seq_err", i), 32'(seq_err), 32'd0);
      end
    end
    check("gap result", 32'(result), 32'(RES_A));
    handshake("hsGap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_result_packer.md
# matrix_result_packer

Collects the stream of element products from the 2x2 multiplier datapath and sums each product pair into one result element. The products are tagged with the same 0..7 entry index that drives the Matrix-B element selector. The block packs the four sums into a flat result matrix that uses the same element ordering as the operand matrices. It then holds that result under a valid/ready handshake until the consumer takes it. It is the write-back end of the multiply path: the B selector unpacks operand elements by entry index, and this block packs result elements by entry index.

## Interface
- EW, default 3: operand element width. Product width PW = 2*EW; result element width RW = 2*EW+1.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product/entry pair is presented this cycle.
- in_ready  out  1  block can accept a pair; low while a completed result is pending.
- entry  in  4  entry index 0..7 of the current product.
- product  in  PW  unsigned product A(i,k)*B(k,j).
- result  out  4*RW  packed result: C00 [RW-1:0], C01 [2RW-1:RW], C10 [3RW-1:2RW], C11 [4RW-1:3RW].
- result_valid  out  1  result holds a complete matrix.
- result_ready  in  1  consumer accepts the result.
- seq_err  out  1  one-cycle pulse when an out-of-order entry is rejected.

## Operation
- Entry-to-element map: entries 0,1 map to C00; 2,3 to C01; 4,5 to C10; 6,7 to C11. An even entry is the first term of a pair and an odd entry is the second.
- A pair is accepted on a posedge when in_valid && in_ready.
- State machine:
  - IDLE: waiting for entry 0.
  - ACCUM: expecting entry exp, where 1 <= exp <= 7.
  - FULL: result pending.
- Accepted entry == exp:
  - Even entry: acc <= product, zero-extended to RW.
  - Odd entry: the element field at index entry>>1 is written with acc + product. This sum is RW bits wide and never overflows.
  - exp increments. Accepting entry 7 writes C11, sets result_valid, and moves to FULL.
- Accepted entry != exp:
  - seq_err pulses for one cycle and the current frame is aborted.
  - If the offending entry is 0, it starts a new frame: acc <= product, exp <= 1, state ACCUM.
  - Otherwise the pair is discarded and the state returns to IDLE.
  - Entries 8..15 are always errors.
- Fields of an aborted or in-progress frame may be partially overwritten. The result output is only meaningful while result_valid is high.
- FULL: in_ready = 0. When result_valid && result_ready, result_valid clears and the state goes to IDLE. result stays unchanged until the next frame overwrites fields.
- in_ready = 1 in IDLE and ACCUM.

## Timing
- Reset values: result = 0, result_valid = 0, seq_err = 0, in_ready = 1, state IDLE, exp = 0, acc = 0.
- Latency: entry 7 is accepted on edge N, and result/result_valid are valid immediately after edge N.
- Minimum frame time is 8 cycles accept-to-valid. Back-to-back frames need one handshake cycle each.
- The handshake cycle and entry 0 of the next frame are never accepted together, because in_ready is low in FULL.
- The upstream B selector updates on negedge, so products are stable half a cycle before this block samples them on posedge.
- result_ready high while result_valid is low: ignored.
- Asynchronous reset mid-frame or during FULL clears everything immediately. No pulse is emitted on seq_err.

## Structure
- Shared package holds:
  - EW, PW and RW;
  - the state enum (IDLE, ACCUM, FULL);
  - the ENTRY_LAST = 7 constant;
  - a function mapping entry to element slot (entry>>1).
- Sub-module: pair_accumulator. It holds acc, takes the even/odd write enable, and produces the RW-bit sum. The FSM, expected-entry counter and packing stay in the top level.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,0]]. Feed products 5, 14, 6, 0, 15, 28, 18, 0 on entries 0..7.
  - Required: result = 28'h24AC313 (C00=19, C01=6, C10=43, C11=18), with result_valid rising after the 8th accept.
- All products 49 (EW=3 maximum). Required: every field equals 7'd98, with no overflow.
- Hold result_ready low for 5 cycles after completion.
  - Required: in_ready stays low and result is stable.
  - Then ready goes high for 1 cycle, result_valid drops, and the next entry 0 is accepted.
- Entries 0, 1, 3: seq_err pulses on entry 3, the state returns to IDLE and no result_valid is raised. Entries 0, 1, 0: the second entry 0 restarts the frame with exp = 1.
- Assert rst_n low after entry 4. Required: all outputs return to their reset values asynchronously, and a full frame afterwards packs correctly.
- in_valid toggling every other cycle across a frame. Required: same result as the first case, with valid asserted only after the 8th accepted pair.
